tdc_result_builder: RTL

Downstream stage of the TDC core. It consumes the start/stop fine bin codes and the coarse count when a measurement finishes. It computes the signed time interval in tap units, tags each result with a sequence number, and buffers results in a small first-word-fall-through (FWFT) FIFO. Readout uses a valid/ready handshake toward the readout/host interface.

---
 rtl/tdc_pkg.sv | 44 ++++
 rtl/tdc_result_fifo.sv | 67 ++++++
 rtl/tdc_result_builder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// tdc_pkg
// Shared constants and the result record for the TDC back end.
// The result record is also consumed by the readout block, so its
// layout ({seq, err, interval}) must stay in sync with that side.
// build_result turns one captured measurement into a signed interval
// in tap units, clamped to zero with err set when it comes out negative.
package tdc_pkg;

    localparam int FINE_W     = 5;
    localparam int COARSE_W   = 4;
    // Taps per clock period; the fine code covers exactly one period.
    localparam int TAPS       = 32;
    localparam int SEQ_W      = 4;
    localparam int INTERVAL_W = COARSE_W + FINE_W + 1;
    // One extra bit over the interval so a negative raw value is visible.
    localparam int RAW_W      = COARSE_W + FINE_W + 2;

    typedef struct packed {
        logic [SEQ_W-1:0]      seq;
        logic                  err;
        logic [INTERVAL_W-1:0] interval;
    } tdc_result_t;

    function automatic tdc_result_t build_result(
        input logic [COARSE_W-1:0] coarse,
        input logic [FINE_W-1:0]   b_start,
        input logic [FINE_W-1:0]   b_stop,
        input logic [SEQ_W-1:0]    seq
    );
        tdc_result_t      res;
        logic [RAW_W-1:0] raw;
        raw = RAW_W'(coarse) * RAW_W'(TAPS) + RAW_W'(b_start) - RAW_W'(b_stop);
        res.seq = seq;
        if (raw[RAW_W-1]) begin
            res.err      = 1'b1;
            res.interval = '0;
        end else begin
            res.err      = 1'b0;
            res.interval = raw[INTERVAL_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/tdc_result_fifo.sv
// tdc_result_fifo
// Generic synchronous first-word-fall-through FIFO. The head entry is
// presented on pop_data whenever empty is low. Pointers carry one extra
// wrap bit so full and empty can be told apart when the indices match.
// A push into a full FIFO is accepted only if a pop happens on the same
// edge; a pop on an empty FIFO is ignored. There is no write-to-read
// bypass, so a word pushed into an empty FIFO is visible one cycle later.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   push        - write push_data this edge (if room)
//   push_data   - word to write
//   pop         - discard the head word this edge (if any)
//   pop_data    - head word (valid when !empty)
//   full, empty - occupancy flags
//   level       - number of words held, 0..DEPTH
module tdc_result_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot the simultaneous push lands in, so full + pop
    // still accepts the write.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO without touching storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage has no reset; stale words are never visible because empty
    // guards the head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/tdc_result_builder.sv
// tdc_result_builder
// Turns finished TDC measurements into tagged interval results and
// buffers them for readout.
//   stage 1 (capture): latch fine codes, coarse count and sequence tag
//   stage 2 (compute): interval = coarse*TAPS + start - stop, clamped
//   FIFO write one edge later; readout via valid/ready.
// The sequence tag advances on every capture, including results later
// dropped for lack of room, so gaps in m_seq reveal losses.
// Ports:
//   clk, reset                        - clock, synchronous active-high reset
//   meas_done                         - one-cycle pulse, inputs valid
//   bin_start, bin_stop, coarse_count - measurement data
//   m_valid, m_ready                  - readout handshake
//   m_interval, m_err, m_seq          - head result (zero while empty)
//   fifo_level                        - entries held
//   drop_count                        - saturating count of lost results
module tdc_result_builder
    import tdc_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    meas_done,
    input  logic [FINE_W-1:0]       bin_start,
    input  logic [FINE_W-1:0]       bin_stop,
    input  logic [COARSE_W-1:0]     coarse_count,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [INTERVAL_W-1:0]   m_interval,
    output logic                    m_err,
    output logic [SEQ_W-1:0]        m_seq,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [DROP_W-1:0]       drop_count
);

    localparam logic [SEQ_W-1:0] SEQ_ONE = 1;
    localparam logic [DROP_W-1:0] DROP_ONE = 1;

    logic                s1_valid;
    logic [FINE_W-1:0]   s1_start;
    logic [FINE_W-1:0]   s1_stop;
    logic [COARSE_W-1:0] s1_coarse;
    logic [SEQ_W-1:0]    s1_seq;
    logic [SEQ_W-1:0]    seq_count;

    logic                s2_valid;
    tdc_result_t         s2_result;

    tdc_result_t         head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                drop_event;

    // Capture stage and sequence counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_start  <= '0;
            s1_stop   <= '0;
            s1_coarse <= '0;
            s1_seq    <= '0;
            seq_count <= '0;
        end else begin
            s1_valid <= meas_done;
            if (meas_done) begin
                s1_start  <= bin_start;
                s1_stop   <= bin_stop;
                s1_coarse <= coarse_count;
                s1_seq    <= seq_count;
                seq_count <= seq_count + SEQ_ONE;
            end
        end
    end

    // Compute stage: the registered result is pushed on the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= build_result(s1_coarse, s1_start, s1_stop, s1_seq);
            end
        end
    end

    assign pop        = !fifo_empty && m_ready;
    assign drop_event = s2_valid && fifo_full && !pop;

    // Saturating count of results that found the FIFO full.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop_event && (drop_count != '1)) begin
            drop_count <= drop_count + DROP_ONE;
        end
    end

    tdc_result_fifo #(
        .WIDTH ($bits(tdc_result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s2_valid),
        .push_data (s2_result),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Head fields are forced to zero while empty so unwritten storage
    // never reaches the port.
    assign m_valid    = !fifo_empty;
    assign m_interval = fifo_empty ? '0   : head.interval;
    assign m_err      = fifo_empty ? 1'b0 : head.err;
    assign m_seq      = fifo_empty ? '0   : head.seq;

endmodule
